// File: rtl/psum_neuron.sv
// Integrate-and-fire neuron fed by signed partial-sum beats; fires once per timestep.
// Optional leak before the threshold compare is enabled with `define NEURON_LEAK_EN.
module psum_neuron #(
    parameter int PSUM_WIDTH = 13,
    parameter int VMEM_WIDTH = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  psum_valid,
    input  logic [PSUM_WIDTH-1:0] psum_data,
    input  logic                  psum_last,
    output logic                  psum_ready,
    input  logic [VMEM_WIDTH-1:0] thresh,
    input  logic [VMEM_WIDTH-1:0] leak,
    input  logic                  vmem_clr,
    output logic                  spike_valid,
    output logic                  spike,
    input  logic                  spike_ready,
    output logic [VMEM_WIDTH-1:0] vmem,
    output logic [1:0]            dbg_state_o
);

    // Handshakes: a beat moves when psum_valid && psum_ready on a rising edge;
    // a result moves when spike_valid && spike_ready; valid holds its payload until taken.
    typedef enum logic [1:0] {
        ST_ACC  = 2'd0,
        ST_FIRE = 2'd1,
        ST_OUT  = 2'd2
    } state_t;

    localparam int EW = VMEM_WIDTH + 2;
    localparam logic signed [EW-1:0] VMAX = {3'b000, {(VMEM_WIDTH-1){1'b1}}};
    localparam logic signed [EW-1:0] VMIN = {3'b111, {(VMEM_WIDTH-1){1'b0}}};

    state_t                  state_q;
    logic [VMEM_WIDTH-1:0]   vmem_q;
    logic                    spike_q;
    logic                    psum_ready_q;
    logic                    spike_valid_q;

    logic signed [EW-1:0]    vmem_ext;
    logic signed [EW-1:0]    psum_ext;
    logic [VMEM_WIDTH-1:0]   acc_d;
    logic [VMEM_WIDTH-1:0]   fire_d;
    logic                    fire_hit;

    function automatic logic [VMEM_WIDTH-1:0] sat(input logic signed [EW-1:0] x);
        if (x > VMAX) begin
            sat = VMAX[VMEM_WIDTH-1:0];
        end else if (x < VMIN) begin
            sat = VMIN[VMEM_WIDTH-1:0];
        end else begin
            sat = x[VMEM_WIDTH-1:0];
        end
    endfunction

    assign vmem_ext = $signed({{2{vmem_q[VMEM_WIDTH-1]}}, vmem_q});
    assign psum_ext = $signed({{(EW-PSUM_WIDTH){psum_data[PSUM_WIDTH-1]}}, psum_data});
    assign acc_d    = sat(vmem_ext + psum_ext);

`ifdef NEURON_LEAK_EN
    logic signed [EW-1:0] leak_ext;
    assign leak_ext = $signed({2'b00, leak});
    assign fire_d   = sat(vmem_ext - leak_ext);
`else
    logic leak_unused;
    assign leak_unused = ^leak;
    assign fire_d      = vmem_q;
`endif

    assign fire_hit = $signed(fire_d) >= $signed(thresh);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= ST_ACC;
            vmem_q        <= '0;
            spike_q       <= 1'b0;
            psum_ready_q  <= 1'b1;
            spike_valid_q <= 1'b0;
        end else if (vmem_clr) begin
            // Clear wins over any beat or pending result in the same cycle.
            state_q       <= ST_ACC;
            vmem_q        <= '0;
            spike_q       <= 1'b0;
            psum_ready_q  <= 1'b1;
            spike_valid_q <= 1'b0;
        end else begin
            case (state_q)
                ST_ACC: begin
                    if (psum_valid && psum_ready_q) begin
                        vmem_q <= acc_d;
                        if (psum_last) begin
                            state_q      <= ST_FIRE;
                            psum_ready_q <= 1'b0;
                        end
                    end
                end
                ST_FIRE: begin
                    spike_q       <= fire_hit;
                    vmem_q        <= fire_hit ? '0 : fire_d;
                    spike_valid_q <= 1'b1;
                    state_q       <= ST_OUT;
                end
                ST_OUT: begin
                    if (spike_ready) begin
                        state_q       <= ST_ACC;
                        spike_q       <= 1'b0;
                        spike_valid_q <= 1'b0;
                        psum_ready_q  <= 1'b1;
                    end
                end
                default: begin
                    state_q       <= ST_ACC;
                    spike_q       <= 1'b0;
                    spike_valid_q <= 1'b0;
                    psum_ready_q  <= 1'b1;
                end
            endcase
        end
    end

    assign psum_ready  = psum_ready_q;
    assign spike_valid = spike_valid_q;
    assign spike       = spike_q;
    assign vmem        = vmem_q;
    assign dbg_state_o = state_q;

endmodule

// File: tb/tb_psum_neuron.sv
// Bench for psum_neuron: vector table, hand-written corner sequences, randomized timesteps.
module tb_psum_neuron;

    localparam int PW = 13;
    localparam int VW = 16;
`ifdef NEURON_LEAK_EN
    localparam bit LEAK_ON = 1'b1;
`else
    localparam bit LEAK_ON = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst;
    logic          psum_valid;
    logic [PW-1:0] psum_data;
    logic          psum_last;
    logic          psum_ready;
    logic [VW-1:0] thresh;
    logic [VW-1:0] leak;
    logic          vmem_clr;
    logic          spike_valid;
    logic          spike;
    logic          spike_ready;
    logic [VW-1:0] vmem;
    logic [1:0]    dbg_state;

    int n_checks = 0;
    int n_errors = 0;

    psum_neuron #(.PSUM_WIDTH(PW), .VMEM_WIDTH(VW)) dut (
        .clk(clk), .rst(rst),
        .psum_valid(psum_valid), .psum_data(psum_data), .psum_last(psum_last),
        .psum_ready(psum_ready), .thresh(thresh), .leak(leak), .vmem_clr(vmem_clr),
        .spike_valid(spike_valid), .spike(spike), .spike_ready(spike_ready),
        .vmem(vmem), .dbg_state_o(dbg_state)
    );

    always #5 clk = ~clk;

    initial begin
        #3000000;
        $display("FAIL watchdog: act=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    typedef struct {
        int d[4];
        int n;
        int th;
        int lk;
        bit clr;
        int exp_pre;
        bit exp_spike;
        int exp_vmem;
    } vec_t;

    vec_t vecs[7];

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: act=%0d exp=%0d", name, act, exp);
        end
    endtask

    function automatic int vm();
        return int'($signed(vmem));
    endfunction

    function automatic int clamp(input int x);
        if (x > 32767) return 32767;
        if (x < -32768) return -32768;
        return x;
    endfunction

    task automatic do_clr();
        vmem_clr = 1'b1;
        @(posedge clk);
        @(negedge clk);
        vmem_clr = 1'b0;
    endtask

    // Called at a negedge; returns at the negedge after the beat is taken.
    task automatic send_beat(input int d, input bit last);
        int k;
        psum_valid = 1'b1;
        psum_data  = d[PW-1:0];
        psum_last  = last;
        for (k = 0; k < 50; k++) begin
            if (psum_ready) break;
            @(negedge clk);
        end
        if (k == 50) chk("beat_ready_timeout", 0, 1);
        @(posedge clk);
        @(negedge clk);
        psum_valid = 1'b0;
        psum_last  = 1'b0;
    endtask

    // Starts at the negedge right after the last beat was accepted (FIRE cycle).
    task automatic finish_step(input string tag, input int exp_pre, input bit exp_spike,
                               input int exp_vmem, input int hold);
        chk({tag, " pre_vmem"}, vm(), exp_pre);
        chk({tag, " fire_valid"}, int'(spike_valid), 0);
        chk({tag, " fire_ready"}, int'(psum_ready), 0);
        @(negedge clk);
        chk({tag, " out_valid"}, int'(spike_valid), 1);
        chk({tag, " spike"}, int'(spike), int'(exp_spike));
        chk({tag, " post_vmem"}, vm(), exp_vmem);
        for (int h = 0; h < hold; h++) begin
            @(negedge clk);
            chk({tag, " hold_valid"}, int'(spike_valid), 1);
            chk({tag, " hold_spike"}, int'(spike), int'(exp_spike));
        end
        spike_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        spike_ready = 1'b0;
        chk({tag, " done_valid"}, int'(spike_valid), 0);
        chk({tag, " done_spike"}, int'(spike), 0);
        chk({tag, " done_ready"}, int'(psum_ready), 1);
    endtask

    task automatic set_vec(input int i, input int d0, input int d1, input int d2, input int d3,
                           input int n, input int th, input int lk, input bit clr,
                           input int pre, input bit sp, input int post);
        vecs[i].d[0] = d0; vecs[i].d[1] = d1; vecs[i].d[2] = d2; vecs[i].d[3] = d3;
        vecs[i].n = n; vecs[i].th = th; vecs[i].lk = lk; vecs[i].clr = clr;
        vecs[i].exp_pre = pre; vecs[i].exp_spike = sp; vecs[i].exp_vmem = post;
    endtask

    initial begin
        int m, pre, vp, nb, d;
        bit sp;

        rst = 1'b1; psum_valid = 1'b0; psum_data = '0; psum_last = 1'b0;
        thresh = '0; leak = '0; vmem_clr = 1'b0; spike_ready = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("rst psum_ready", int'(psum_ready), 1);
        chk("rst spike_valid", int'(spike_valid), 0);
        chk("rst spike", int'(spike), 0);
        chk("rst vmem", vm(), 0);
        rst = 1'b0;
        @(negedge clk);

        // psum_last without psum_valid must be ignored
        psum_last = 1'b1;
        @(negedge clk);
        chk("last_no_valid ready", int'(psum_ready), 1);
        psum_last = 1'b0;

        set_vec(0, 40, 40, 30, 0, 3, 100, 0, 1, 110, 1, 0);
        set_vec(1, 50, -20, 0, 0, 2, 100, 0, 0, 30, 0, 30);
        set_vec(2, 80, 0, 0, 0, 1, 100, 0, 0, 110, 1, 0);
        if (LEAK_ON) set_vec(3, 60, 50, 0, 0, 2, 100, 15, 1, 110, 0, 95);
        else         set_vec(3, 60, 50, 0, 0, 2, 100, 15, 1, 110, 1, 0);
        set_vec(4, -3, 0, 0, 0, 1, -5, 0, 1, -3, 1, 0);
        set_vec(5, 0, 0, 0, 0, 1, 0, 0, 1, 0, 1, 0);
        set_vec(6, -10, 0, 0, 0, 1, -5, 0, 1, -10, 0, -10);

        for (int i = 0; i < 7; i++) begin
            if (vecs[i].clr) do_clr();
            thresh = vecs[i].th[VW-1:0];
            leak   = vecs[i].lk[VW-1:0];
            for (int b = 0; b < vecs[i].n; b++)
                send_beat(vecs[i].d[b], b == vecs[i].n - 1);
            finish_step($sformatf("vec%0d", i), vecs[i].exp_pre, vecs[i].exp_spike,
                        vecs[i].exp_vmem, i % 3);
        end

        // Positive saturation
        leak = '0;
        do_clr();
        thresh = 16'sd32767;
        for (int b = 0; b < 8; b++) send_beat(4095, 1'b0);
        chk("sat_pos 32760", vm(), 32760);
        send_beat(4095, 1'b1);
        finish_step("sat_pos", 32767, 1'b1, 0, 0);

        // Negative saturation
        do_clr();
        thresh = '0;
        for (int b = 0; b < 7; b++) send_beat(-4096, 1'b0);
        send_beat(-1328, 1'b0);
        chk("sat_neg -30000", vm(), -30000);
        send_beat(-4096, 1'b0);
        chk("sat_neg clamp1", vm(), -32768);
        send_beat(-4096, 1'b0);
        chk("sat_neg clamp2", vm(), -32768);
        send_beat(-4096, 1'b1);
        finish_step("sat_neg", -32768, 1'b0, -32768, 0);

        // Backpressure: result held, upstream beat waits, taken right after handshake
        do_clr();
        thresh = 16'sd100;
        send_beat(40, 1'b0); send_beat(40, 1'b0); send_beat(30, 1'b1);
        @(negedge clk);
        psum_valid = 1'b1; psum_data = 13'sd7; psum_last = 1'b0;
        for (int h = 0; h < 5; h++) begin
            @(negedge clk);
            chk("bp spike_valid", int'(spike_valid), 1);
            chk("bp spike", int'(spike), 1);
            chk("bp psum_ready", int'(psum_ready), 0);
            chk("bp vmem", vm(), 0);
        end
        spike_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        spike_ready = 1'b0;
        chk("bp after_hs valid", int'(spike_valid), 0);
        chk("bp after_hs vmem", vm(), 0);
        @(posedge clk);
        @(negedge clk);
        psum_valid = 1'b0;
        chk("bp beat_taken", vm(), 7);

        // vmem_clr in OUT drops the result; clr in ACC blocks a beat
        do_clr();
        send_beat(120, 1'b1);
        @(negedge clk);
        chk("clr_out valid_before", int'(spike_valid), 1);
        do_clr();
        chk("clr_out valid", int'(spike_valid), 0);
        chk("clr_out vmem", vm(), 0);
        chk("clr_out ready", int'(psum_ready), 1);
        psum_valid = 1'b1; psum_data = 13'sd55; vmem_clr = 1'b1;
        @(posedge clk);
        @(negedge clk);
        psum_valid = 1'b0; vmem_clr = 1'b0;
        chk("clr_acc beat_dropped", vm(), 0);

        // Asynchronous reset mid-ACC
        send_beat(70, 1'b0);
        chk("rst_mid vmem70", vm(), 70);
        #2 rst = 1'b1;
        #1;
        chk("rst_mid async vmem", vm(), 0);
        chk("rst_mid async valid", int'(spike_valid), 0);
        @(negedge clk);
        rst = 1'b0;
        send_beat(30, 1'b1);
        finish_step("rst_mid next", 30, 1'b0, 30, 0);

        // Randomized timesteps against an arithmetic model
        do_clr();
        m = 0;
        for (int t = 0; t < 40; t++) begin
            if ($urandom_range(0, 9) == 0) begin
                do_clr();
                m = 0;
            end
            thresh = VW'($urandom_range(0, 12000) - 2000);
            leak   = VW'($urandom_range(0, 60));
            nb = $urandom_range(1, 5);
            for (int b = 0; b < nb; b++) begin
                d = $urandom_range(0, 8191) - 4096;
                m = clamp(m + d);
                send_beat(d, b == nb - 1);
            end
            pre = m;
            vp  = LEAK_ON ? clamp(m - int'(leak)) : m;
            sp  = vp >= int'($signed(thresh));
            m   = sp ? 0 : vp;
            finish_step($sformatf("rnd%0d", t), pre, sp, m, $urandom_range(0, 3));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/psum_neuron.md
PSUM_NEURON -- requirements
Module: psum_neuron

Interface
REQ-001 SHALL have parameter PSUM_WIDTH, default 13, meaning signed partial-sum width from the upstream accumulator.
REQ-002 SHALL have parameter VMEM_WIDTH, default 16, meaning signed membrane-potential width (VMEM_WIDTH > PSUM_WIDTH).
REQ-003 SHALL have port clk  input  1  the single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have port psum_valid  input  1  partial-sum beat present.
REQ-006 SHALL have port psum_data  input  PSUM_WIDTH  signed two's-complement partial sum.
REQ-007 SHALL have port psum_last  input  1  beat is the last partial sum of the current timestep.
REQ-008 SHALL have port psum_ready  output  1  block accepts a beat this cycle.
REQ-009 SHALL have port thresh  input  VMEM_WIDTH  signed firing threshold, sampled in FIRE.
REQ-010 SHALL have port leak  input  VMEM_WIDTH  unsigned leak magnitude (used only with NEURON_LEAK_EN).
REQ-011 SHALL have port vmem_clr  input  1  synchronous clear of potential and state machine.
REQ-012 SHALL have port spike_valid  output  1  spike result available.
REQ-013 SHALL have port spike  output  1  1 = neuron fired this timestep, 0 = no fire.
REQ-014 SHALL have port spike_ready  input  1  downstream accepts the result.
REQ-015 SHALL have port vmem  output  VMEM_WIDTH  current membrane potential (registered).

Function
REQ-016 SHALL implement states ACC, FIRE, OUT; psum_ready = 1 only in ACC, spike_valid = 1 only in OUT.
REQ-017 SHALL accept a beat when psum_valid && psum_ready, updating vmem <= sat(vmem + sign_extend(psum_data)) next edge.
REQ-018 SHALL saturate every addition/subtraction to [-2^(VMEM_WIDTH-1), 2^(VMEM_WIDTH-1)-1] (16-bit: -32768..32767); no wrap-around.
REQ-019 SHALL transition ACC -> FIRE on an accepted beat with psum_last = 1; otherwise remain in ACC; psum_last without psum_valid ignored.
REQ-020 SHALL in FIRE (exactly one cycle): compute v' = vmem (or leaked value per REQ-029), signed-compare v' >= thresh; if true register spike = 1 and vmem <= 0, else spike = 0 and vmem <= v'; go to OUT.
REQ-021 SHALL hold spike_valid and spike stable in OUT until spike_valid && spike_ready, then return to ACC next edge.
REQ-022 SHALL give latency: last beat accepted at edge N -> FIRE during cycle N..N+1 -> spike_valid asserted after edge N+1 (2 cycles).
REQ-023 SHALL keep psum_ready low throughout FIRE and OUT (backpressure upstream; no beat lost or double-counted).
REQ-024 SHALL on vmem_clr = 1 (any state) set vmem <= 0, spike <= 0, state <= ACC next edge; a beat presented in the same cycle is NOT accumulated; a pending OUT result is dropped.
REQ-025 SHALL drive spike = 0 whenever spike_valid = 0.

Reset
REQ-026 SHALL on rst = 1 immediately (asynchronously) force state ACC, vmem = 0, spike = 0, spike_valid = 0, psum_ready = 1 after release.
REQ-027 SHALL on reset mid-operation (any state) discard partial accumulation and any pending spike; first edge after rst deassertion behaves as fresh ACC.

Configuration
REQ-028 SHALL gate leak logic with macro NEURON_LEAK_EN.
REQ-029 SHALL with NEURON_LEAK_EN defined: v' = sat(vmem - leak) in FIRE, prior to threshold compare; without it: v' = vmem, leak port present but unused.

Verification
REQ-030 SHALL cover: thresh=100, beats 40, 40, 30(last) -> vmem 110 pre-fire, spike_valid=1 spike=1, vmem=0 after FIRE.
REQ-031 SHALL cover: thresh=100, beats 50, -20(last) -> spike=0, vmem=30 retained; next timestep beat 80(last) -> spike=1, vmem=0.
REQ-032 SHALL cover: vmem=32760 via prior beats, beat 4095 -> vmem=32767; repeated -4096 beats from -30000 -> vmem=-32768.
REQ-033 SHALL cover: spike_ready low 5 cycles in OUT -> spike_valid/spike held, psum_ready=0, upstream beat held and accepted first cycle after handshake.
REQ-034 SHALL cover: vmem_clr in OUT and rst asserted mid-ACC (vmem=70) -> spike_valid=0, vmem=0 immediately/next edge, next timestep starts from 0.
REQ-035 SHALL cover (NEURON_LEAK_EN): leak=15, thresh=100, beats 60, 50(last) -> v'=95, spike=0, vmem=95; without macro same stimulus -> spike=1, vmem=0.
